// File: rtl/base_eu_pkg.sv
// Shared definitions for the base execution-unit scheduler: EU select codes,
// legality check and the result-queue entry layout.
package base_eu_pkg;

    localparam int SELW      = 6;
    localparam int ENT_DATAW = 64;
    localparam int ENT_TAGW  = 8;
    localparam int ENT_SRCW  = 3;

    typedef enum logic [SELW-1:0] {
        SEL_LUI = 6'd0, SEL_AUIPC,
        SEL_ADD, SEL_SUB, SEL_SLL, SEL_SLT, SEL_SLTU, SEL_XOR,
        SEL_SRL, SEL_SRA, SEL_OR, SEL_AND,
        SEL_ADDI, SEL_SLTI, SEL_SLTIU, SEL_XORI, SEL_ORI, SEL_ANDI,
        SEL_SLLI, SEL_SRLI, SEL_SRAI,
        SEL_ADDW, SEL_SUBW, SEL_SLLW, SEL_SRLW, SEL_SRAW,
        SEL_ADDIW, SEL_SLLIW, SEL_SRLIW, SEL_SRAIW,
        SEL_FENCE, SEL_ECALL, SEL_EBREAK, SEL_PAUSE
    } eu_sel_e;

    // Entry fields are sized for the widest supported configuration.
    typedef struct packed {
        logic [ENT_DATAW-1:0] data;
        logic [ENT_TAGW-1:0]  tag;
        logic [ENT_SRCW-1:0]  src;
    } res_entry_t;

    // Everything from FENCE upward (and any unassigned code) produces no result.
    function automatic logic is_base_legal(input logic [SELW-1:0] sel);
        return (sel < SEL_FENCE);
    endfunction

endpackage

// File: rtl/base_eu_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping,
// and returns it as a one-hot grant plus a binary index.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Two passes: ports at/after ptr first, then the wrapped ports below ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDXW'(i);
            end else begin
                any = any;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDXW'(i);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/base_eu_sched.sv
// Shares one combinational base integer EU between NREQ issue ports with
// round-robin arbitration and a 2-entry result queue under valid/ready.
module base_eu_sched
    import base_eu_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int XLEN = 64,
    parameter  int TAGW = 5,
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_op1,
    input  logic [NREQ*XLEN-1:0] req_op2,
    input  logic [NREQ*SELW-1:0] req_sel,
    input  logic [NREQ*TAGW-1:0] req_tag,
    input  logic                 flush,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [XLEN-1:0]      res_data,
    output logic [TAGW-1:0]      res_tag,
    output logic [SRCW-1:0]      res_src
);

    localparam int SHW = $clog2(XLEN);

    logic [NREQ-1:0] grant_s;
    logic [SRCW-1:0] gidx_s;
    logic            any_s;
    logic [SRCW-1:0] ptr_r;
    logic [SRCW-1:0] nxt_ptr_s;

    logic [XLEN-1:0] a_s;
    logic [XLEN-1:0] b_s;
    logic [SELW-1:0] sel_s;
    logic [TAGW-1:0] tag_s;
    logic [XLEN-1:0] eu_res_s;
    logic [31:0]     w_s;
    logic [SHW-1:0]  sh_s;

    res_entry_t q_r [2];
    res_entry_t new_ent_s;
    logic       head_r;
    logic [1:0] count_r;
    logic       wr_idx_s;
    logic       pop_s;
    logic       space_s;
    logic       ready_en_s;
    logic       push_s;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_r),
        .grant (grant_s),
        .idx   (gidx_s),
        .any   (any_s)
    );

    // Accept control: a slot is free if the queue is not full or the head leaves now.
    always_comb begin
        pop_s      = (count_r != 2'd0) && res_ready;
        space_s    = (count_r != 2'd2) || pop_s;
        ready_en_s = space_s && !flush && rst_n;
        req_ready  = grant_s & {NREQ{ready_en_s}};
        push_s     = any_s && ready_en_s;
        wr_idx_s   = head_r ^ count_r[0];
        if (gidx_s == SRCW'(NREQ - 1)) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = gidx_s + SRCW'(1);
        end
    end

    // One-hot operand mux from the granted port into the shared EU.
    always_comb begin
        a_s   = '0;
        b_s   = '0;
        sel_s = '0;
        tag_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_s   = a_s   | (req_op1[i*XLEN +: XLEN] & {XLEN{grant_s[i]}});
            b_s   = b_s   | (req_op2[i*XLEN +: XLEN] & {XLEN{grant_s[i]}});
            sel_s = sel_s | (req_sel[i*SELW +: SELW] & {SELW{grant_s[i]}});
            tag_s = tag_s | (req_tag[i*TAGW +: TAGW] & {TAGW{grant_s[i]}});
        end
    end

    // Base integer EU; immediate forms arrive with the immediate already on op2.
    always_comb begin
        eu_res_s = '0;
        w_s      = 32'd0;
        sh_s     = b_s[SHW-1:0];
        if (is_base_legal(sel_s)) begin
            case (sel_s)
                SEL_LUI:               eu_res_s = sext32({b_s[19:0], 12'h000});
                SEL_AUIPC:             eu_res_s = a_s + {{(XLEN-32){1'b0}}, b_s[19:0], 12'h000};
                SEL_ADD, SEL_ADDI:     eu_res_s = a_s + b_s;
                SEL_SUB:               eu_res_s = a_s + ~b_s + {{(XLEN-1){1'b0}}, 1'b1};
                SEL_SLL, SEL_SLLI:     eu_res_s = a_s << sh_s;
                SEL_SLT, SEL_SLTI:     eu_res_s = {{(XLEN-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
                SEL_SLTU, SEL_SLTIU:   eu_res_s = {{(XLEN-1){1'b0}}, (a_s < b_s)};
                SEL_XOR, SEL_XORI:     eu_res_s = a_s ^ b_s;
                SEL_SRL, SEL_SRLI:     eu_res_s = a_s >> sh_s;
                SEL_SRA, SEL_SRAI:     eu_res_s = $signed(a_s) >>> sh_s;
                SEL_OR, SEL_ORI:       eu_res_s = a_s | b_s;
                SEL_AND, SEL_ANDI:     eu_res_s = a_s & b_s;
                SEL_ADDW, SEL_ADDIW: begin
                    w_s      = a_s[31:0] + b_s[31:0];
                    eu_res_s = sext32(w_s);
                end
                SEL_SUBW: begin
                    w_s      = a_s[31:0] + ~b_s[31:0] + 32'd1;
                    eu_res_s = sext32(w_s);
                end
                SEL_SLLW, SEL_SLLIW: begin
                    w_s      = a_s[31:0] << b_s[4:0];
                    eu_res_s = sext32(w_s);
                end
                SEL_SRLW, SEL_SRLIW: begin
                    w_s      = a_s[31:0] >> b_s[4:0];
                    eu_res_s = sext32(w_s);
                end
                SEL_SRAW, SEL_SRAIW: begin
                    w_s      = $signed(a_s[31:0]) >>> b_s[4:0];
                    eu_res_s = sext32(w_s);
                end
                default:               eu_res_s = '0;
            endcase
        end else begin
            eu_res_s = '0;
        end
    end

    // Pack the EU result with its routing information for the queue tail.
    always_comb begin
        new_ent_s      = '0;
        new_ent_s.data = ENT_DATAW'(eu_res_s);
        new_ent_s.tag  = ENT_TAGW'(tag_s);
        new_ent_s.src  = ENT_SRCW'(gidx_s);
    end

    // Result queue, head/count tracking and round-robin pointer; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r[0]  <= '0;
            q_r[1]  <= '0;
            head_r  <= 1'b0;
            count_r <= 2'd0;
            ptr_r   <= '0;
        end else if (flush) begin
            head_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (push_s) begin
                q_r[wr_idx_s] <= new_ent_s;
                ptr_r         <= nxt_ptr_s;
            end
            case ({push_s, pop_s})
                2'b10: count_r <= count_r + 2'd1;
                2'b01: begin
                    count_r <= count_r - 2'd1;
                    head_r  <= ~head_r;
                end
                2'b11:   head_r  <= ~head_r;
                default: count_r <= count_r;
            endcase
        end
    end

    assign res_valid = (count_r != 2'd0);
    assign res_data  = XLEN'(q_r[head_r].data);
    assign res_tag   = TAGW'(q_r[head_r].tag);
    assign res_src   = SRCW'(q_r[head_r].src);

endmodule

// File: tb/tb_base_eu_sched.sv
// Directed bench for base_eu_sched: queue/arbiter reference model checked every
// cycle on the falling edge, plus hand-computed literal expectations.
module tb_base_eu_sched;
    import base_eu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic [11:0]  req_sel;
    logic [9:0]   req_tag;
    logic         flush;
    logic         res_valid;
    logic         res_ready;
    logic [63:0]  res_data;
    logic [4:0]   res_tag;
    logic [0:0]   res_src;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] d;
        logic [4:0]  t;
        logic        s;
    } ent_t;
    ent_t mq[$];
    int   mptr = 0;

    base_eu_sched #(.NREQ(2), .XLEN(64), .TAGW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel), .req_tag(req_tag),
        .flush(flush),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_src(res_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Architectural meaning of the selects exercised here.
    function automatic logic [63:0] eu_model(input logic [5:0] sel, input logic [63:0] a, input logic [63:0] b);
        logic [31:0] lo;
        case (sel)
            SEL_ADD, SEL_ADDI: return a + b;
            SEL_SUB:           return a - b;
            SEL_XOR:           return a ^ b;
            SEL_SLTU:          return (a < b) ? 64'd1 : 64'd0;
            SEL_AUIPC:         return a + (b & 64'hFFFFF) * 64'd4096;
            SEL_LUI: begin
                lo = b[19:0] * 32'd4096;
                return sx32(lo);
            end
            SEL_ADDW: begin
                lo = a[31:0] + b[31:0];
                return sx32(lo);
            end
            SEL_SUBW: begin
                lo = a[31:0] - b[31:0];
                return sx32(lo);
            end
            default:           return 64'd0;
        endcase
    endfunction

    task automatic set_port(input int p, input logic [5:0] sel, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] tag);
        req_sel[p*6 +: 6]   = sel;
        req_op1[p*64 +: 64] = a;
        req_op2[p*64 +: 64] = b;
        req_tag[p*5 +: 5]   = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: compare against current model state, then advance it by one edge.
    always @(negedge clk) begin
        int          g;
        int          cand;
        bit          space;
        logic [1:0]  exp_ready;
        logic [63:0] a;
        logic [63:0] b;
        ent_t        e;
        if (!rst_n) begin
            check("rst_res_valid", {63'd0, res_valid}, 64'd0);
            check("rst_req_ready", {62'd0, req_ready}, 64'd0);
            check("rst_res_data", res_data, 64'd0);
            check("rst_res_tag", {59'd0, res_tag}, 64'd0);
            check("rst_res_src", {63'd0, res_src}, 64'd0);
            mq.delete();
            mptr = 0;
        end else begin
            g = -1;
            for (int k = 0; k < 2; k++) begin
                cand = (mptr + k) % 2;
                if (g < 0 && req_valid[cand]) g = cand;
            end
            space = (mq.size() < 2) || (mq.size() > 0 && res_ready);
            exp_ready = 2'b00;
            if (g >= 0 && space && !flush) exp_ready[g] = 1'b1;
            check("m_req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
            check("m_res_valid", {63'd0, res_valid}, (mq.size() > 0) ? 64'd1 : 64'd0);
            if (mq.size() > 0) begin
                check("m_res_data", res_data, mq[0].d);
                check("m_res_tag", {59'd0, res_tag}, {59'd0, mq[0].t});
                check("m_res_src", {63'd0, res_src}, {63'd0, mq[0].s});
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && res_ready) void'(mq.pop_front());
                if (exp_ready != 2'b00) begin
                    a   = req_op1[g*64 +: 64];
                    b   = req_op2[g*64 +: 64];
                    e.d = eu_model(req_sel[g*6 +: 6], a, b);
                    e.t = req_tag[g*5 +: 5];
                    e.s = (g == 1);
                    mq.push_back(e);
                    mptr = (g + 1) % 2;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; res_ready = 1'b0; req_valid = 2'b11;
        req_op1 = '0; req_op2 = '0; req_sel = '0; req_tag = '0;
        tick(); tick();
        check("reset_req_ready", {62'd0, req_ready}, 64'd0);
        check("reset_res_valid", {63'd0, res_valid}, 64'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;

        // single port ADD
        set_port(0, SEL_ADD, 64'd5, 64'd7, 5'd3);
        req_valid = 2'b01; res_ready = 1'b1;
        #1 check("single_ready", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        check("single_valid", {63'd0, res_valid}, 64'd1);
        check("single_data", res_data, 64'd12);
        check("single_tag", {59'd0, res_tag}, 64'd3);
        check("single_src", {63'd0, res_src}, 64'd0);
        tick();
        check("single_drained", {63'd0, res_valid}, 64'd0);

        // fill two entries, then asynchronous reset mid-cycle
        res_ready = 1'b0;
        set_port(0, SEL_ADD, 64'd1, 64'd1, 5'd1);
        set_port(1, SEL_ADD, 64'd2, 64'd2, 5'd2);
        req_valid = 2'b11;
        tick(); tick();
        check("two_queued_valid", {63'd0, res_valid}, 64'd1);
        check("two_queued_ready", {62'd0, req_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1 check("async_rst_valid", {63'd0, res_valid}, 64'd0);
        tick();

        // round robin after reset: grants 0,1,0,1
        set_port(0, SEL_ADD, 64'd100, 64'd1, 5'd4);
        set_port(1, SEL_SUB, 64'd10, 64'd3, 5'd9);
        res_ready = 1'b1; req_valid = 2'b11; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_grant", {62'd0, req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i == 1) begin
                check("rr_head_port0", res_data, 64'd101);
                check("rr_src_port0", {63'd0, res_src}, 64'd0);
            end
            if (i == 2) begin
                check("rr_sub_result", res_data, 64'd7);
                check("rr_src_port1", {63'd0, res_src}, 64'd1);
            end
            tick();
        end
        req_valid = 2'b00;
        tick(); tick();

        // backpressure
        res_ready = 1'b0;
        set_port(0, SEL_XOR, 64'hF0, 64'h0F, 5'd2);
        set_port(1, SEL_AUIPC, 64'h1000, 64'd5, 5'd6);
        req_valid = 2'b11;
        #1 check("bp_grant0", {62'd0, req_ready}, 64'd1);
        tick();
        #1 check("bp_grant1", {62'd0, req_ready}, 64'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_full_ready", {62'd0, req_ready}, 64'd0);
            check("bp_hold_data", res_data, 64'hFF);
            check("bp_hold_tag", {59'd0, res_tag}, 64'd2);
            tick();
        end
        req_valid = 2'b00; res_ready = 1'b1;
        #1 check("bp_pop0_data", res_data, 64'hFF);
        tick();
        check("bp_pop1_data", res_data, 64'h6000);
        check("bp_pop1_src", {63'd0, res_src}, 64'd1);
        tick();
        check("bp_empty", {63'd0, res_valid}, 64'd0);

        // full queue with simultaneous pop and push
        res_ready = 1'b0;
        set_port(0, SEL_ADDW, 64'h7FFF_FFFF, 64'd1, 5'd10);
        set_port(1, SEL_SUBW, 64'd0, 64'd1, 5'd11);
        req_valid = 2'b11;
        tick(); tick();
        set_port(1, SEL_FENCE, 64'd5, 64'd5, 5'd12);
        req_valid = 2'b10; res_ready = 1'b1;
        #1 check("fs_ready", {62'd0, req_ready}, 64'd2);
        check("fs_head_addw", res_data, 64'hFFFF_FFFF_8000_0000);
        tick();
        req_valid = 2'b00;
        check("fs_still_valid", {63'd0, res_valid}, 64'd1);
        check("fs_head_subw", res_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("fs_tag_subw", {59'd0, res_tag}, 64'd11);
        tick();
        check("fs_fence_data", res_data, 64'd0);
        check("fs_fence_tag", {59'd0, res_tag}, 64'd12);
        check("fs_fence_src", {63'd0, res_src}, 64'd1);
        tick();
        check("fs_empty", {63'd0, res_valid}, 64'd0);

        // flush with a full queue and port0 requesting
        res_ready = 1'b0;
        set_port(0, SEL_LUI, 64'd0, 64'h80000, 5'd13);
        set_port(1, SEL_SLTU, 64'd1, 64'd2, 5'd14);
        req_valid = 2'b11;
        tick(); tick();
        check("fl_head_lui", res_data, 64'hFFFF_FFFF_8000_0000);
        set_port(0, SEL_ADD, 64'd3, 64'd4, 5'd15);
        req_valid = 2'b01; flush = 1'b1;
        #1 check("fl_ready", {62'd0, req_ready}, 64'd0);
        tick();
        flush = 1'b0; req_valid = 2'b00;
        check("fl_valid", {63'd0, res_valid}, 64'd0);
        set_port(1, SEL_ECALL, 64'd1, 64'd2, 5'd7);
        req_valid = 2'b11; res_ready = 1'b1;
        #1 check("fl_ptr_kept", {62'd0, req_ready}, 64'd1);
        tick();
        check("fl_new_data", res_data, 64'd7);
        check("fl_new_tag", {59'd0, res_tag}, 64'd15);
        tick();
        check("fl_ecall_data", res_data, 64'd0);
        check("fl_ecall_tag", {59'd0, res_tag}, 64'd7);
        check("fl_ecall_src", {63'd0, res_src}, 64'd1);
        req_valid = 2'b00;
        tick();
        check("fl_drained", {63'd0, res_valid}, 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
